// File: rtl/set_count_pkg.sv
// Shared types and constants for the set_count_gen lattice counter.
// Legacy func encodings map the old four-mode SET block onto the truth table.
package set_count_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam int DRAIN_CYC = 3;

  localparam logic [7:0] FUNC_A   = 8'hAA;
  localparam logic [7:0] FUNC_AND = 8'h88;
  localparam logic [7:0] FUNC_XOR = 8'h66;
  localparam logic [7:0] FUNC_TWO = 8'h68;

endpackage

// File: rtl/set_dist_cmp.sv
// One-circle distance slice: S1 difference, S2 squared distance, S3 compare.
// Macro SET_COUNT_STRICT_EN selects strict (<) membership instead of <=.
module set_dist_cmp #(
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW-1:0]   cx,
  input  logic [CW-1:0]   cy,
  input  logic [CW-1:0]   px,
  input  logic [CW-1:0]   py,
  input  logic [2*CW-1:0] rsq,
  output logic            hit
);

  localparam int SW = 2*CW+1;

  logic signed [CW:0]   dx;
  logic signed [CW:0]   dy;
  logic signed [SW-1:0] ex;
  logic signed [SW-1:0] ey;
  logic        [SW-1:0] sq;
  logic        [SW-1:0] dsq;
  logic                 hit_d;

  // the true sum is below 2^SW, so modular width arithmetic is exact
  always_comb begin
    ex = {{CW{dx[CW]}}, dx};
    ey = {{CW{dy[CW]}}, dy};
    sq = SW'(ex * ex + ey * ey);
  end

  always_comb begin
`ifdef SET_COUNT_STRICT_EN
    hit_d = dsq < {1'b0, rsq};
`else
    hit_d = dsq <= {1'b0, rsq};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx  <= '0;
      dy  <= '0;
      dsq <= '0;
      hit <= 1'b0;
    end else begin
      dx  <= $signed({1'b0, cx}) - $signed({1'b0, px});
      dy  <= $signed({1'b0, cy}) - $signed({1'b0, py});
      dsq <= sq;
      hit <= hit_d;
    end
  end

endmodule

// File: rtl/set_count_gen.sv
// Counts lattice points whose circle-membership vector is selected by func.
// Build option: SET_COUNT_STRICT_EN makes circle membership strict.
module set_count_gen
  import set_count_pkg::*;
#(
  parameter int CW     = 4,
  parameter int NCIRC  = 3,
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int CNT_W  = $clog2(GRID_W*GRID_H+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCIRC*2*CW-1:0] central,
  input  logic [NCIRC*CW-1:0]   radius,
  input  logic [2**NCIRC-1:0]   func,
  output logic                  busy,
  output logic                  valid,
  output logic [CNT_W-1:0]      candidate
);

  localparam logic [CW-1:0] XMAX = CW'(GRID_W);
  localparam logic [CW-1:0] YMAX = CW'(GRID_H);
  localparam logic [1:0]    DLST = 2'(DRAIN_CYC-1);

  state_t state;
  state_t state_n;

  logic [NCIRC*2*CW-1:0] cen_q;
  logic [NCIRC*CW-1:0]   rad_q;
  logic [2**NCIRC-1:0]   func_q;
  logic [CW-1:0]         px;
  logic [CW-1:0]         py;
  logic [1:0]            dcnt;
  logic [2:0]            vld;
  logic [NCIRC-1:0]      hit;
  logic [CNT_W-1:0]      acc;
  logic [CNT_W-1:0]      acc_n;
  logic                  last_pt;
  logic                  drain_end;
  logic                  idle_ok;
  logic                  sel;

  assign busy      = (state == LOAD) || (state == SCAN) || (state == DRAIN);
  assign valid     = (state == DONE);
  assign idle_ok   = (state == IDLE) || (state == DONE);
  assign last_pt   = (px == XMAX) && (py == YMAX);
  assign drain_end = (dcnt == DLST);
  assign sel       = func_q[hit];
  assign acc_n     = acc + CNT_W'(vld[2] & sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (en) state_n = LOAD;
      LOAD:    state_n = SCAN;
      SCAN:    if (last_pt) state_n = DRAIN;
      DRAIN:   if (drain_end) state_n = DONE;
      DONE:    state_n = en ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_q     <= '0;
      rad_q     <= '0;
      func_q    <= '0;
      px        <= '0;
      py        <= '0;
      dcnt      <= '0;
      vld       <= '0;
      acc       <= '0;
      candidate <= '0;
    end else begin
      if (idle_ok && en) begin
        cen_q  <= central;
        rad_q  <= radius;
        func_q <= func;
      end
      vld <= {vld[1:0], state == SCAN};
      if (state == LOAD) begin
        px  <= CW'(1);
        py  <= CW'(1);
        acc <= '0;
      end else begin
        acc <= acc_n;
      end
      if (state == SCAN) begin
        dcnt <= '0;
        if (px == XMAX) begin
          px <= CW'(1);
          py <= py + CW'(1);
        end else begin
          px <= px + CW'(1);
        end
      end
      // forward the final accumulation so the result lands on the DONE edge
      if (state == DRAIN) begin
        dcnt <= dcnt + 2'd1;
        if (drain_end) candidate <= acc_n;
      end
    end
  end

  for (genvar i = 0; i < NCIRC; i++) begin : g_circ
    logic [CW-1:0]   cx;
    logic [CW-1:0]   cy;
    logic [CW-1:0]   r;
    logic [2*CW-1:0] rsq;

    assign cx = cen_q[(NCIRC-i)*2*CW-1 -: CW];
    assign cy = cen_q[(NCIRC-i)*2*CW-CW-1 -: CW];
    assign r  = rad_q[(NCIRC-i)*CW-1 -: CW];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                rsq <= '0;
      else if (state == LOAD) rsq <= {{CW{1'b0}}, r} * {{CW{1'b0}}, r};
    end

    set_dist_cmp #(.CW(CW)) u_cmp (
      .clk (clk),
      .rst (rst),
      .cx  (cx),
      .cy  (cy),
      .px  (px),
      .py  (py),
      .rsq (rsq),
      .hit (hit[i])
    );
  end

endmodule

// File: doc/set_count_gen.md
Name: set_count_gen

Overview:
- Parametrised successor of the circle-set candidate counter.
- Scans a GRID_W x GRID_H integer lattice (x 1..GRID_W, y 1..GRID_H) against NCIRC circles.
- Counts lattice points whose circle-membership vector is selected by a programmable truth table (func), so any set expression is supported, not only four fixed modes.
- Evaluates one lattice point per cycle through a fixed pipeline. Sits beside the existing SET block as its drop-in generalisation.

Parameters:
- CW, 4, coordinate and radius width in bits; values are unsigned.
- NCIRC, 3, number of circles, legal range 1..4.
- GRID_W, 8, lattice width.
- GRID_H, 8, lattice height. Both GRID_W and GRID_H must be ≤ 2^CW - 1.
- CNT_W, $clog2(GRID_W*GRID_H+1), width of candidate.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only when busy=0.
- central  in  NCIRC*2*CW  circle centres. Circle i occupies central[(NCIRC-i)*2*CW-1 -: 2*CW], with x in the upper CW bits and y in the lower CW bits.
- radius  in  NCIRC*CW  radii. Circle i occupies radius[(NCIRC-i)*CW-1 -: CW].
- func  in  2**NCIRC  truth table. A point is counted iff func[m]=1, where m[i]=1 means the point is inside circle i.
- busy  out  1  job in progress.
- valid  out  1  one-cycle pulse; candidate is final.
- candidate  out  CNT_W  count of selected points.

Behaviour:
- Reset (async, any time, including mid-job): busy=0, valid=0, candidate=0. FSM goes to IDLE; the pipeline and accumulator are cleared. No partial result is ever reported.
- FSM states: IDLE -> LOAD -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE: on an edge with en=1, central, radius and func are captured into registers and the FSM enters LOAD. busy=1 from that edge. en while busy=1 is ignored. Inputs are not required to be held after the capture edge.
- LOAD (1 cycle): compute r_i^2 for all circles in parallel, 2*CW bits each. Clear the accumulator.
- SCAN (GRID_W*GRID_H cycles): issue one point per cycle in raster order, x fastest: (1,1),(2,1)..(GRID_W,1),(1,2)..(GRID_W,GRID_H).
- Pipeline per point:
  - S1: signed differences dx=xi-x and dy=yi-y, CW+1 bits each.
  - S2: dx^2+dy^2, 2*CW+1 bits, no overflow.
  - S3: m[i] = (d_i ≤ r_i^2); sel = func[m].
  - S4: accumulator += sel.
- DRAIN: 3 cycles until the last point leaves S4.
- DONE (1 cycle): candidate <= accumulator, valid=1, busy=0 on the same edge.
- Latency is fixed and independent of func and geometry: capture edge E0 to valid edge = GRID_W*GRID_H+4 cycles (68 for the defaults).
- candidate holds its value until the next DONE or a reset.
- A new en is accepted at the first edge after valid (busy=0), giving back-to-back jobs with one idle cycle.
- Boundaries:
  - Radius 0 counts only a centre lying exactly on the lattice.
  - A centre off the lattice (coordinate 0 or > GRID_W/GRID_H) is legal.
  - The boundary is inclusive (≤).
  - func all-zeros gives 0; func all-ones gives GRID_W*GRID_H.
  - Membership bits for circles i ≥ NCIRC do not exist.
- Legacy equivalence (NCIRC=3): mode0 func=8'hAA, mode1 8'h88, mode2 8'h66, mode3 8'h68.

Optional Feature:
- SET_COUNT_STRICT_EN defined: membership is strict (d_i < r_i^2), so points exactly on a circle are excluded.
- Undefined: inclusive ≤ as above.
- Latency and interface are unchanged either way.

Decomposition:
- Package set_count_pkg holds:
  - FSM state enum (IDLE, LOAD, SCAN, DRAIN, DONE);
  - DRAIN_CYC=3 constant;
  - legacy func constants FUNC_A=8'hAA, FUNC_AND=8'h88, FUNC_XOR=8'h66, FUNC_TWO=8'h68.
- One sub-module is natural: set_dist_cmp (one circle: S1–S3 distance/compare slice, parameter CW), instantiated NCIRC times via generate.

Test Plan:
- Circle 0 centre (4,4), r=2, func=8'hAA, defaults → valid exactly 68 cycles after capture; candidate=13 (9 with SET_COUNT_STRICT_EN).
- Centre (1,1) r=0, func=8'hAA → 1. Centre (0,0) r=0 → 0.
- Any geometry: func=8'hFF → 64; func=8'h00 → 0; busy high for exactly 68 cycles.
- NCIRC=3, all three circles centred at (4,4) r=2, func=8'h68 (exactly two) → 0; func=8'h80 (all three) → 13.
- en pulsed during busy with different inputs → ignored, first result unchanged. Back-to-back jobs: second capture at the edge after valid.
- rst asserted at cycle 30 of a job, then released → busy=0, valid=0, candidate=0 immediately and no valid pulse. A new job then yields the correct count.
